// File: rtl/rst_seq_pkg.sv
// Shared state encodings, reset-cause codes and sizing helper for the reset sequencer.
// RST_SEQ_WDT_EN adds the watchdog cause code.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StRelBus   = 3'd1,
        StRelIo    = 3'd2,
        StRelCpu   = 3'd3,
        StRun      = 3'd4,
        StSwHold   = 3'd5
    } state_e;

    localparam logic [1:0] RST_CAUSE_POR  = 2'b00;
    localparam logic [1:0] RST_CAUSE_LOCK = 2'b01;
    localparam logic [1:0] RST_CAUSE_SOFT = 2'b10;
`ifdef RST_SEQ_WDT_EN
    localparam logic [1:0] RST_CAUSE_WDT  = 2'b11;
`endif

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Multi-flop synchroniser for a single asynchronous level input.
module rst_seq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] ff_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Ordered subsystem reset release (bus, I/O, CPU) with lock-loss and soft-reset re-entry.
// Define RST_SEQ_WDT_EN to add the RUN-state watchdog and the wdt_kick port.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned STAGE_DLY    = 8,
    parameter int unsigned DEBOUNCE_CYC = 16
`ifdef RST_SEQ_WDT_EN
   ,parameter int unsigned WDT_CYC      = 65536
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    input  logic       sw_req,
`ifdef RST_SEQ_WDT_EN
    input  logic       wdt_kick,
`endif
    output logic       bus_reset,
    output logic       io_reset,
    output logic       cpu_reset,
    output logic       rst_busy,
    output logic [1:0] rst_cause
);

    localparam int unsigned CNT_W = $clog2(max2(LOCK_STABLE, STAGE_DLY) + 1);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);

    logic lock_s;
    logic req_s;

    rst_seq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_lock (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (locked),
        .q_o     (lock_s)
    );

    rst_seq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_req (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (sw_req),
        .q_o     (req_s)
    );

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic             req_db_q;

    // db_cnt_q counts consecutive samples disagreeing with req_db_q; the last one flips it.
    logic db_flip;
    logic db_rise;
    logic lock_lost;
    logic soft_hit;

    assign db_flip   = (req_s != req_db_q) && (db_cnt_q == DB_LAST);
    assign db_rise   = db_flip && req_s;
    assign lock_lost = (state_q != StWaitLock) && !lock_s;
    assign soft_hit  = db_rise && (state_q != StWaitLock) && (state_q != StSwHold);

`ifdef RST_SEQ_WDT_EN
    localparam logic [31:0] WDT_LAST = 32'(WDT_CYC - 1);

    logic [31:0] wdt_cnt_q;
    logic        wdt_fire;

    assign wdt_fire = (state_q == StRun) && !wdt_kick && (wdt_cnt_q == WDT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_cnt_q <= '0;
        end else if ((state_q != StRun) || wdt_kick) begin
            wdt_cnt_q <= '0;
        end else if (wdt_cnt_q != WDT_LAST) begin
            wdt_cnt_q <= wdt_cnt_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_q <= '0;
            req_db_q <= 1'b0;
        end else if (req_s == req_db_q) begin
            db_cnt_q <= '0;
        end else if (db_flip) begin
            db_cnt_q <= '0;
            req_db_q <= req_s;
        end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StWaitLock;
            cnt_q     <= '0;
            bus_reset <= 1'b1;
            io_reset  <= 1'b1;
            cpu_reset <= 1'b1;
            rst_busy  <= 1'b1;
            rst_cause <= RST_CAUSE_POR;
        end else if (lock_lost) begin
            state_q   <= StWaitLock;
            cnt_q     <= '0;
            bus_reset <= 1'b1;
            io_reset  <= 1'b1;
            cpu_reset <= 1'b1;
            rst_busy  <= 1'b1;
            rst_cause <= RST_CAUSE_LOCK;
        end else if (soft_hit) begin
            state_q   <= StSwHold;
            cnt_q     <= '0;
            bus_reset <= 1'b1;
            io_reset  <= 1'b1;
            cpu_reset <= 1'b1;
            rst_busy  <= 1'b1;
            rst_cause <= RST_CAUSE_SOFT;
`ifdef RST_SEQ_WDT_EN
        end else if (wdt_fire) begin
            state_q   <= StWaitLock;
            cnt_q     <= '0;
            bus_reset <= 1'b1;
            io_reset  <= 1'b1;
            cpu_reset <= 1'b1;
            rst_busy  <= 1'b1;
            rst_cause <= RST_CAUSE_WDT;
`endif
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    if (!lock_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_q   <= StRelBus;
                        cnt_q     <= '0;
                        bus_reset <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StRelBus: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_q  <= StRelIo;
                        cnt_q    <= '0;
                        io_reset <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StRelIo: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_q   <= StRelCpu;
                        cnt_q     <= '0;
                        cpu_reset <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StRelCpu: begin
                    state_q  <= StRun;
                    rst_busy <= 1'b0;
                end
                StRun: begin
                    state_q <= StRun;
                end
                StSwHold: begin
                    if (!req_db_q) begin
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q   <= StWaitLock;
                    cnt_q     <= '0;
                    bus_reset <= 1'b1;
                    io_reset  <= 1'b1;
                    cpu_reset <= 1'b1;
                    rst_busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: power-on order, lock glitch, lock loss, bouncy soft request,
// lock-loss vs soft-request priority, and (with RST_SEQ_WDT_EN) the watchdog.
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b1;
    logic       sw_req = 1'b0;
`ifdef RST_SEQ_WDT_EN
    logic       wdt_kick = 1'b0;
`endif
    logic       bus_reset;
    logic       io_reset;
    logic       cpu_reset;
    logic       rst_busy;
    logic [1:0] rst_cause;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rst_seq #(
        .SYNC_STAGES  (2),
        .LOCK_STABLE  (16),
        .STAGE_DLY    (8),
        .DEBOUNCE_CYC (16)
`ifdef RST_SEQ_WDT_EN
       ,.WDT_CYC      (100)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .locked    (locked),
        .sw_req    (sw_req),
`ifdef RST_SEQ_WDT_EN
        .wdt_kick  (wdt_kick),
`endif
        .bus_reset (bus_reset),
        .io_reset  (io_reset),
        .cpu_reset (cpu_reset),
        .rst_busy  (rst_busy),
        .rst_cause (rst_cause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ref = sample at which locked became (or already was) stable high with the FSM in WAIT_LOCK.
    task automatic check_release(input string tag);
        tick(17);
        check({tag, "_bus_hold"}, {29'd0, bus_reset, io_reset, cpu_reset}, 32'b111);
        tick(1);
        check({tag, "_bus_rel"}, {29'd0, bus_reset, io_reset, cpu_reset}, 32'b011);
        tick(7);
        check({tag, "_io_hold"}, {29'd0, bus_reset, io_reset, cpu_reset}, 32'b011);
        tick(1);
        check({tag, "_io_rel"}, {29'd0, bus_reset, io_reset, cpu_reset}, 32'b001);
        tick(7);
        check({tag, "_cpu_hold"}, {29'd0, bus_reset, io_reset, cpu_reset}, 32'b001);
        tick(1);
        check({tag, "_cpu_rel"}, {28'd0, bus_reset, io_reset, cpu_reset, rst_busy}, 32'b0001);
        tick(1);
        check({tag, "_busy_low"}, {31'd0, rst_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(2);
        check("rst_outputs", {28'd0, bus_reset, io_reset, cpu_reset, rst_busy}, 32'hf);
        check("rst_cause", {30'd0, rst_cause}, 32'd0);

        // 1: power-on release order
        reset = 1'b0;
        check_release("por");
        check("por_cause", {30'd0, rst_cause}, 32'd0);

        // 2: one-cycle lock glitch at cnt=10 restarts the stability count
        reset = 1'b1;
        tick(2);
        check("rst2_busy", {31'd0, rst_busy}, 32'd1);
        reset = 1'b0;
        tick(10);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(7);
        check("glitch_no_early_rel", {31'd0, bus_reset}, 32'd1);
        tick(10);
        check("glitch_bus_hold", {31'd0, bus_reset}, 32'd1);
        tick(1);
        check("glitch_bus_rel", {31'd0, bus_reset}, 32'd0);
        check("glitch_cause", {30'd0, rst_cause}, 32'd0);
        tick(20);
        check("glitch_run", {31'd0, rst_busy}, 32'd0);

        // 3: lock loss in RUN
        locked = 1'b0;
        tick(2);
        check("ll_pre", {28'd0, bus_reset, io_reset, cpu_reset, rst_busy}, 32'h0);
        tick(1);
        check("ll_assert", {28'd0, bus_reset, io_reset, cpu_reset, rst_busy}, 32'hf);
        check("ll_cause", {30'd0, rst_cause}, 32'd1);
        locked = 1'b1;
        check_release("ll");

        // 4: bouncy soft request; only the held phase triggers
        repeat (5) begin
            sw_req = 1'b1;
            tick(3);
            sw_req = 1'b0;
            tick(3);
        end
        check("bounce_ignored", {28'd0, bus_reset, io_reset, cpu_reset, rst_busy}, 32'h0);
        sw_req = 1'b1;
        tick(17);
        check("soft_pre", {29'd0, bus_reset, io_reset, cpu_reset}, 32'b000);
        tick(1);
        check("soft_assert", {28'd0, bus_reset, io_reset, cpu_reset, rst_busy}, 32'hf);
        check("soft_cause", {30'd0, rst_cause}, 32'd2);
        tick(2);
        sw_req = 1'b0;
        tick(17);
        check("soft_hold", {28'd0, bus_reset, io_reset, cpu_reset, rst_busy}, 32'hf);
        check_release("soft");
        check("soft_cause_kept", {30'd0, rst_cause}, 32'd2);

        // 5: lock loss on the same edge req_db rises -> lock loss wins, WAIT_LOCK
        sw_req = 1'b1;
        tick(15);
        locked = 1'b0;
        tick(2);
        check("simul_pre", {31'd0, bus_reset}, 32'd0);
        tick(1);
        check("simul_assert", {28'd0, bus_reset, io_reset, cpu_reset, rst_busy}, 32'hf);
        check("simul_cause", {30'd0, rst_cause}, 32'd1);
        // Release proceeds with sw_req still held, which SW_HOLD would block.
        locked = 1'b1;
        check_release("simul");
        sw_req = 1'b0;
        tick(40);
        check("simul_run", {28'd0, bus_reset, io_reset, cpu_reset, rst_busy}, 32'h0);
        check("simul_cause_kept", {30'd0, rst_cause}, 32'd1);

`ifdef RST_SEQ_WDT_EN
        // 6: kicks every 50 cycles keep RUN; then starve the watchdog
        repeat (6) begin
            wdt_kick = 1'b1;
            tick(1);
            wdt_kick = 1'b0;
            tick(49);
        end
        check("wdt_kicked", {31'd0, rst_busy}, 32'd0);
        wdt_kick = 1'b1;
        tick(1);
        wdt_kick = 1'b0;
        tick(99);
        check("wdt_pre", {31'd0, bus_reset}, 32'd0);
        tick(1);
        check("wdt_assert", {28'd0, bus_reset, io_reset, cpu_reset, rst_busy}, 32'hf);
        check("wdt_cause", {30'd0, rst_cause}, 32'd3);
        tick(40);
        check("wdt_rerun", {31'd0, rst_busy}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
